// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the core requesters, the arbiter and the bus bridge.
// The arbiter connects through the slave modport; the core/bridge side uses master.
interface sram_port_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like bus port between instruction fetch and data access, one transaction at a time.
// Define ARB_TIMEOUT_EN to add a WAIT watchdog that returns 32'hDEAD_BEEF and sets a sticky err.
//
// state | meaning
// IDLE  | nothing outstanding; arbitrate and latch the winner
// REQ   | mem_req high, waiting for mem_addr_ok
// WAIT  | address accepted, waiting for mem_data_ok
module sram_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic               clk,
   input  logic               resetn,
   sram_port_arbiter_if.slave bus,
   output logic               busy,
   output logic               err
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 1 = data requester owns the transaction
   logic [3:0]  starve_q, starve_d;
   logic        mem_wr_q, mem_wr_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        inst_addr_ok_q, inst_addr_ok_d;
   logic        data_addr_ok_q, data_addr_ok_d;
   logic        inst_data_ok_q, inst_data_ok_d;
   logic        data_data_ok_q, data_data_ok_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        grant_data, grant_inst, rsp_valid;
   logic [31:0] rsp_data;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      starve_d       = starve_q;
      mem_wr_d       = mem_wr_q;
      mem_wstrb_d    = mem_wstrb_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      inst_addr_ok_d = 1'b0;
      data_addr_ok_d = 1'b0;
      inst_data_ok_d = 1'b0;
      data_data_ok_d = 1'b0;
      inst_rdata_d   = inst_rdata_q;
      data_rdata_d   = data_rdata_q;
      grant_data     = 1'b0;
      grant_inst     = 1'b0;
      rsp_valid      = 1'b0;
      rsp_data       = bus.mem_rdata;
`ifdef ARB_TIMEOUT_EN
      tmo_d          = tmo_q;
      err_d          = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            grant_data = bus.data_req && (!bus.inst_req || (starve_q < STARVE_LIM));
            grant_inst = bus.inst_req && !grant_data;
            if (grant_data) begin
               owner_d        = 1'b1;
               mem_wr_d       = bus.data_wr;
               mem_wstrb_d    = bus.data_wstrb;
               mem_addr_d     = bus.data_addr;
               mem_wdata_d    = bus.data_wdata;
               data_addr_ok_d = 1'b1;
               state_d        = REQ;
               if (bus.inst_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
            end else if (grant_inst) begin
               owner_d        = 1'b0;
               mem_wr_d       = 1'b0;
               mem_wstrb_d    = 4'h0;
               mem_addr_d     = bus.inst_addr;
               mem_wdata_d    = 32'h0;
               inst_addr_ok_d = 1'b1;
               starve_d       = 4'h0;
               state_d        = REQ;
            end
         end
         REQ: begin
            if (bus.mem_addr_ok) begin
               if (bus.mem_data_ok) begin
                  rsp_valid = 1'b1;
               end else begin
                  state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                  tmo_d   = TMO_LOAD;
`endif
               end
            end
         end
         WAIT: begin
            if (bus.mem_data_ok) begin
               rsp_valid = 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_q == '0) begin
               rsp_valid = 1'b1;
               rsp_data  = 32'hDEAD_BEEF;
               err_d     = 1'b1;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      if (rsp_valid) begin
         state_d = IDLE;
         if (owner_q) begin
            data_data_ok_d = 1'b1;
            data_rdata_d   = rsp_data;
         end else begin
            inst_data_ok_d = 1'b1;
            inst_rdata_d   = rsp_data;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= IDLE;
         owner_q        <= 1'b0;
         starve_q       <= 4'h0;
         mem_wr_q       <= 1'b0;
         mem_wstrb_q    <= 4'h0;
         mem_addr_q     <= 32'h0;
         mem_wdata_q    <= 32'h0;
         inst_addr_ok_q <= 1'b0;
         data_addr_ok_q <= 1'b0;
         inst_data_ok_q <= 1'b0;
         data_data_ok_q <= 1'b0;
         inst_rdata_q   <= 32'h0;
         data_rdata_q   <= 32'h0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         starve_q       <= starve_d;
         mem_wr_q       <= mem_wr_d;
         mem_wstrb_q    <= mem_wstrb_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         inst_addr_ok_q <= inst_addr_ok_d;
         data_addr_ok_q <= data_addr_ok_d;
         inst_data_ok_q <= inst_data_ok_d;
         data_data_ok_q <= data_data_ok_d;
         inst_rdata_q   <= inst_rdata_d;
         data_rdata_q   <= data_rdata_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign bus.inst_addr_ok = inst_addr_ok_q;
   assign bus.inst_data_ok = inst_data_ok_q;
   assign bus.inst_rdata   = inst_rdata_q;
   assign bus.data_addr_ok = data_addr_ok_q;
   assign bus.data_data_ok = data_data_ok_q;
   assign bus.data_rdata   = data_rdata_q;
   assign bus.mem_req      = (state_q == REQ);
   assign bus.mem_wr       = mem_wr_q;
   assign bus.mem_wstrb    = mem_wstrb_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed steps plus a random phase, every cycle checked against a
// transaction-level reference model (free/outstanding/accepted, starvation count, latched fields).
module tb_sram_port_arbiter;
   localparam int STARVE = 4;
   localparam int TO     = 16;

   typedef struct {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dreq_t;

   logic clk = 1'b0;
   logic resetn;
   logic busy, err;

   sram_port_arbiter_if bus_if ();

   sram_port_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if),
      .busy   (busy),
      .err    (err)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model
   bit          m_out, m_acc, m_owner, m_err;
   int          m_starve, m_wait;
   logic        m_wr;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;

   // requesters and grant log (1 = data)
   logic [31:0] iq[$];
   dreq_t       dq[$];
   bit          glog[$];

   // bridge behaviour knobs
   bit          br_rand, br_hang, br_comb, br_seen, br_pend, stray_req;
   int          br_alat, br_dlat, br_ca, br_cd;
   logic [31:0] br_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus_if.inst_req    = 1'b0;
      bus_if.inst_addr   = 32'h0;
      bus_if.data_req    = 1'b0;
      bus_if.data_wr     = 1'b0;
      bus_if.data_wstrb  = 4'h0;
      bus_if.data_addr   = 32'h0;
      bus_if.data_wdata  = 32'h0;
      bus_if.mem_addr_ok = 1'b0;
      bus_if.mem_data_ok = 1'b0;
      bus_if.mem_rdata   = 32'h0;
   endtask

   task automatic env_reset();
      m_out = 0; m_acc = 0; m_owner = 0; m_err = 0; m_starve = 0; m_wait = 0;
      m_wr = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
      iq.delete(); dq.delete();
      br_seen = 0; br_pend = 0; stray_req = 0; br_hang = 0; br_comb = 0;
      drive_idle();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_inst_addr_ok"}, bus_if.inst_addr_ok, 0);
      chk({tag, "_inst_data_ok"}, bus_if.inst_data_ok, 0);
      chk({tag, "_inst_rdata"},   bus_if.inst_rdata,   0);
      chk({tag, "_data_addr_ok"}, bus_if.data_addr_ok, 0);
      chk({tag, "_data_data_ok"}, bus_if.data_data_ok, 0);
      chk({tag, "_data_rdata"},   bus_if.data_rdata,   0);
      chk({tag, "_mem_req"},      bus_if.mem_req,      0);
      chk({tag, "_mem_wr"},       bus_if.mem_wr,       0);
      chk({tag, "_mem_wstrb"},    bus_if.mem_wstrb,    0);
      chk({tag, "_mem_addr"},     bus_if.mem_addr,     0);
      chk({tag, "_mem_wdata"},    bus_if.mem_wdata,    0);
      chk({tag, "_busy"},         busy,                0);
      chk({tag, "_err"},          err,                 0);
   endtask

   // One clock: predict from the spec rules, advance, check every output, then drive the next cycle.
   task automatic tick();
      bit          exp_ia = 0, exp_da = 0, exp_iok = 0, exp_dok = 0, done = 0;
      logic [31:0] rv;
      rv = bus_if.mem_rdata;
      if (!m_out) begin
         if (bus_if.data_req && (!bus_if.inst_req || m_starve < STARVE)) begin
            exp_da = 1;
            if (bus_if.inst_req && m_starve < 15) m_starve++;
            m_owner = 1; m_wr = bus_if.data_wr; m_wstrb = bus_if.data_wstrb;
            m_addr = bus_if.data_addr; m_wdata = bus_if.data_wdata;
            m_out = 1; m_acc = 0;
         end else if (bus_if.inst_req) begin
            exp_ia = 1;
            m_starve = 0;
            m_owner = 0; m_wr = 0; m_wstrb = 0; m_addr = bus_if.inst_addr; m_wdata = 0;
            m_out = 1; m_acc = 0;
         end
      end else if (!m_acc) begin
         if (bus_if.mem_addr_ok && bus_if.mem_data_ok) done = 1;
         else if (bus_if.mem_addr_ok) begin m_acc = 1; m_wait = 0; end
      end else if (bus_if.mem_data_ok) done = 1;
`ifdef ARB_TIMEOUT_EN
      else begin
         m_wait++;
         if (m_wait == TO) begin done = 1; rv = 32'hDEAD_BEEF; m_err = 1; end
      end
`endif
      if (done) begin
         m_out = 0; m_acc = 0;
         if (m_owner) begin exp_dok = 1; m_drdata = rv; end
         else begin exp_iok = 1; m_irdata = rv; end
      end

      @(posedge clk);
      #1;
      chk("inst_addr_ok", bus_if.inst_addr_ok, exp_ia);
      chk("data_addr_ok", bus_if.data_addr_ok, exp_da);
      chk("inst_data_ok", bus_if.inst_data_ok, exp_iok);
      chk("data_data_ok", bus_if.data_data_ok, exp_dok);
      chk("inst_rdata",   bus_if.inst_rdata,   m_irdata);
      chk("data_rdata",   bus_if.data_rdata,   m_drdata);
      chk("busy",         busy,                m_out);
      chk("mem_req",      bus_if.mem_req,      m_out && !m_acc);
      chk("mem_addr",     bus_if.mem_addr,     m_addr);
      chk("mem_wr",       bus_if.mem_wr,       m_wr);
      chk("mem_wstrb",    bus_if.mem_wstrb,    m_wstrb);
      chk("mem_wdata",    bus_if.mem_wdata,    m_wdata);
      chk("err",          err,                 m_err);

      if (bus_if.inst_addr_ok) glog.push_back(1'b0);
      if (bus_if.data_addr_ok) glog.push_back(1'b1);

      if (bus_if.inst_addr_ok) bus_if.inst_req = 1'b0;
      if (!bus_if.inst_req && iq.size() != 0) begin
         bus_if.inst_addr = iq.pop_front();
         bus_if.inst_req  = 1'b1;
      end
      if (bus_if.data_addr_ok) bus_if.data_req = 1'b0;
      if (!bus_if.data_req && dq.size() != 0) begin
         dreq_t r;
         r = dq.pop_front();
         bus_if.data_wr    = r.wr;
         bus_if.data_wstrb = r.wstrb;
         bus_if.data_addr  = r.addr;
         bus_if.data_wdata = r.wdata;
         bus_if.data_req   = 1'b1;
      end

      bus_if.mem_addr_ok = 1'b0;
      bus_if.mem_data_ok = 1'b0;
      if (bus_if.mem_req) begin
         if (!br_seen) begin
            br_seen = 1;
            br_ca   = br_rand ? int'($urandom_range(0, 3)) : br_alat;
         end
         if (br_ca == 0) begin
            bus_if.mem_addr_ok = 1'b1;
            br_seen = 0;
            if (br_comb) begin
               bus_if.mem_data_ok = 1'b1;
               bus_if.mem_rdata   = br_rand ? $urandom() : br_rdata;
            end else if (!br_hang) begin
               br_pend = 1;
               br_cd   = br_rand ? int'($urandom_range(0, 4)) : br_dlat;
            end
         end else begin
            br_ca--;
         end
      end else if (br_pend) begin
         if (br_cd == 0) begin
            bus_if.mem_data_ok = 1'b1;
            bus_if.mem_rdata   = br_rand ? $urandom() : br_rdata;
            br_pend = 0;
         end else begin
            br_cd--;
         end
      end else if (stray_req) begin
         bus_if.mem_data_ok = 1'b1;
         bus_if.mem_rdata   = $urandom();
         stray_req = 0;
      end
   endtask

   task automatic settle(input string tag, input int max_cyc);
      int n = 0;
      do begin
         tick();
         n++;
      end while ((iq.size() != 0 || dq.size() != 0 || bus_if.inst_req || bus_if.data_req || m_out)
                 && n < max_cyc);
      chk({tag, "_settle_in_budget"}, (n < max_cyc), 1);
   endtask

   initial begin
      bit exp3 [7];
      int pulses;

      resetn = 1'b0;
      env_reset();
      br_rand = 0; br_alat = 0; br_dlat = 0; br_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      resetn = 1'b1;

      // single fetch
      br_alat = 2; br_dlat = 2; br_rdata = 32'h2408_0001;
      iq.push_back(32'h1FC0_0000);
      settle("t1", 50);
      chk("t1_inst_rdata", bus_if.inst_rdata, 32'h2408_0001);
      chk("t1_mem_addr",   bus_if.mem_addr,   32'h1FC0_0000);
      chk("t1_mem_wr",     bus_if.mem_wr,     0);
      chk("t1_data_rdata", bus_if.data_rdata, 0);

      // simultaneous requests: data first, then inst
      glog.delete();
      br_alat = 0; br_dlat = 0; br_rdata = 32'h1111_2222;
      iq.push_back(32'h0000_0100);
      dq.push_back('{1'b0, 4'h0, 32'h0000_0200, 32'h0});
      settle("t2", 50);
      chk("t2_grants", glog.size(), 2);
      if (glog.size() == 2) begin
         chk("t2_first_is_data", glog[0], 1);
         chk("t2_second_is_inst", glog[1], 0);
      end

      // starvation: inst held, six data requests back-to-back
      glog.delete();
      br_alat = 1; br_dlat = 1; br_rdata = 32'h3333_0000;
      iq.push_back(32'h1FC0_0010);
      for (int i = 0; i < 6; i++) dq.push_back('{1'b0, 4'h0, 32'h0000_0300 + 32'(i * 4), 32'h0});
      settle("t3", 200);
      exp3 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      chk("t3_grants", glog.size(), 7);
      if (glog.size() == 7)
         for (int i = 0; i < 7; i++) chk($sformatf("t3_grant%0d", i), glog[i], exp3[i]);

      // store fields stable through REQ
      br_alat = 2; br_dlat = 1; br_rdata = 32'h0;
      dq.push_back('{1'b1, 4'b0011, 32'h0000_1004, 32'hCAFE_1234});
      for (int i = 0; i < 10 && !bus_if.mem_req; i++) tick();
      chk("t4_req_seen", bus_if.mem_req, 1);
      for (int i = 0; i < 10 && bus_if.mem_req; i++) begin
         chk("t4_mem_wr",    bus_if.mem_wr,    1);
         chk("t4_mem_wstrb", bus_if.mem_wstrb, 4'b0011);
         chk("t4_mem_addr",  bus_if.mem_addr,  32'h0000_1004);
         chk("t4_mem_wdata", bus_if.mem_wdata, 32'hCAFE_1234);
         tick();
      end
      settle("t4", 50);

      // combined addr_ok/data_ok, then a stray response while idle
      br_comb = 1; br_alat = 1; br_rdata = 32'h5A5A_0005;
      dq.push_back('{1'b0, 4'h0, 32'h0000_2000, 32'h0});
      settle("t5", 50);
      chk("t5_data_rdata", bus_if.data_rdata, 32'h5A5A_0005);
      br_comb = 0;
      stray_req = 1;
      pulses = 0;
      repeat (5) begin
         tick();
         pulses += int'(bus_if.inst_data_ok) + int'(bus_if.data_data_ok);
      end
      chk("t5_stray_pulses", pulses, 0);
      chk("t5_rdata_held", bus_if.data_rdata, 32'h5A5A_0005);

`ifdef ARB_TIMEOUT_EN
      // watchdog: bridge never answers
      br_hang = 1; br_alat = 0;
      iq.push_back(32'h0000_3000);
      settle("t6_tmo", 60);
      chk("t6_tmo_rdata", bus_if.inst_rdata, 32'hDEAD_BEEF);
      chk("t6_tmo_err", err, 1);
      br_hang = 0;
      stray_req = 1;
      repeat (3) tick();
      chk("t6_err_sticky", err, 1);
      chk("t6_late_rsp_ignored", bus_if.inst_rdata, 32'hDEAD_BEEF);
`endif

      // reset while waiting for data
      br_hang = 1; br_alat = 0;
      iq.push_back(32'h0000_4000);
      for (int i = 0; i < 10 && !m_acc; i++) tick();
      repeat (3) tick();
      chk("t6_in_wait", busy, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      env_reset();
      @(posedge clk);
      #1;
      chk_all_zero("held_reset");
      resetn = 1'b1;

      // random traffic
      br_rand = 1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 1) iq.push_back($urandom());
         if ($urandom_range(0, 3) != 0)
            dq.push_back('{1'($urandom()), 4'($urandom()), $urandom(), $urandom()});
      end
      settle("rand", 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "time limit");
   end
endmodule
